// File: rtl/rom_syn_pkg.sv
// Shared defaults and content rule for the 64x4 synchronous ROM.
package rom_syn_pkg;

    localparam int unsigned DEF_ADDR_W = 6;
    localparam int unsigned DEF_DATA_W = 4;

    // Word idx of the ROM: (5*idx + 3) mod 2**data_w.
    function automatic int unsigned ROM_INIT(input int unsigned idx, input int unsigned data_w);
        return (5 * idx + 3) % (32'd1 << data_w);
    endfunction

endpackage

// File: rtl/rom_syn_out_reg.sv
// Enable-qualified output register with asynchronous active-low clear.
module rom_syn_out_reg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/rom_syn_64x4.sv
// 64x4 synchronous ROM with registered, enable-held output.
// Define ROM_SYN_OUT_REG_EN to add a second output stage (2-cycle read latency).
module rom_syn_64x4
    import rom_syn_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dout
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] rom_tbl [DEPTH];
    logic [DATA_W-1:0] rom_word;
    logic [DATA_W-1:0] stage1_q;

    // Constant table; every address value maps to a valid entry.
    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom_tbl[i] = DATA_W'(ROM_INIT(i, DATA_W));
    end

    assign rom_word = rom_tbl[addr];

    rom_syn_out_reg #(
        .WIDTH (DATA_W)
    ) u_stage1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (en),
        .d_i   (rom_word),
        .q_o   (stage1_q)
    );

`ifdef ROM_SYN_OUT_REG_EN
    logic en_q;

    // Enable travels with the data so stage 2 only advances behind a real read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en;
        end
    end

    rom_syn_out_reg #(
        .WIDTH (DATA_W)
    ) u_stage2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (en_q),
        .d_i   (stage1_q),
        .q_o   (dout)
    );
`else
    assign dout = stage1_q;
`endif

endmodule

// File: tb/tb_rom_syn_64x4.sv
// Self-checking bench for rom_syn_64x4: directed reads, hold, reset, sweep and random traffic.
module tb_rom_syn_64x4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [5:0] addr;
    logic [3:0] dout;

    int n_vec;
    int n_err;

    // Reference: read results land after a fixed number of enabled pipeline steps.
    int unsigned ref_s1;
    int unsigned ref_s2;
    bit          ref_en_d;

    rom_syn_64x4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .addr  (addr),
        .dout  (dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int unsigned rom_ref(input int unsigned a);
        return (5 * a + 3) % 16;
    endfunction

    function automatic logic [3:0] model_out();
`ifdef ROM_SYN_OUT_REG_EN
        return 4'(ref_s2);
`else
        return 4'(ref_s1);
`endif
    endfunction

    task automatic model_reset();
        ref_s1   = 0;
        ref_s2   = 0;
        ref_en_d = 1'b0;
    endtask

    task automatic model_edge(input logic e, input logic [5:0] a);
        if (ref_en_d) ref_s2 = ref_s1;
        if (e) ref_s1 = rom_ref(int'(a));
        ref_en_d = e;
    endtask

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: dout=%0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at posedge+1; optionally scribbles on the inputs before settling on the real ones.
    task automatic step(input string tag, input logic e, input logic [5:0] a, input bit glitch);
        if (glitch) begin
            en   = ~e;
            addr = 6'($urandom);
            #2;
            check_eq({tag, "_midcycle"}, dout, model_out());
        end
        en   = e;
        addr = a;
        @(posedge clk);
        model_edge(e, a);
        #1;
        check_eq(tag, dout, model_out());
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        addr  = '0;
        #1;
        check_eq("reset_init", dout, 4'd0);
        for (int i = 0; i < 2; i++) begin
            en = 1'b1;
            addr = 6'd63;
            @(posedge clk);
            #1;
            check_eq("reset_held", dout, 4'd0);
        end
        rst_n = 1'b1;
        en = 1'b0;

        // Sequential reads, then drain so each result is visible.
        step("seq63", 1'b1, 6'd63, 1'b0);
        step("seq1", 1'b1, 6'd1, 1'b0);
        step("seq22", 1'b1, 6'd22, 1'b0);
        step("seq19", 1'b1, 6'd19, 1'b0);
        step("seq61", 1'b1, 6'd61, 1'b0);
        step("drain61", 1'b0, 6'd61, 1'b0);
        check_eq("seq61_val", dout, 4'd4);

        step("hold19", 1'b0, 6'd19, 1'b0);
        step("hold35", 1'b0, 6'd35, 1'b0);
        step("hold49", 1'b0, 6'd49, 1'b0);
        check_eq("hold_val", dout, 4'd4);

        step("reen35", 1'b1, 6'd35, 1'b0);
        step("reen_drain", 1'b0, 6'd0, 1'b0);
        check_eq("reen35_val", dout, 4'd2);

        // Asynchronous reset with dout=8.
        step("pre_rst1", 1'b1, 6'd1, 1'b0);
        step("pre_rst_drain", 1'b0, 6'd1, 1'b0);
        check_eq("pre_rst_val", dout, 4'd8);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("rst_async", dout, 4'd0);
        @(posedge clk);
        #1;
        check_eq("rst_low_edge", dout, 4'd0);
        rst_n = 1'b1;
        step("post_rst22", 1'b1, 6'd22, 1'b0);
        step("post_rst_drain", 1'b0, 6'd22, 1'b0);
        check_eq("post_rst_val", dout, 4'd1);

        for (int a = 0; a < 64; a++) begin
            step("sweep", 1'b1, 6'(a), 1'b0);
        end
        step("sweep_drain", 1'b0, 6'd0, 1'b0);
        check_eq("sweep_last", dout, 4'd14);

        for (int i = 0; i < 300; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), 6'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
